// File: rtl/memory_cycle.sv
// memory_cycle: M stage with variable-latency data memory and the M/W pipeline register
module memory_cycle #(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 10,
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        ResultSrcM,
    input  logic [4:0]  RD_M,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] ALU_ResultM,
    output logic        StallM,
    output logic        RegWriteW,
    output logic [4:0]  RD_W,
    output logic        ResultSrcW,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ResultW
);
    localparam int CW = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_LATENCY - 1);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0] mem [DEPTH];
    logic access, unused_addr;
    logic [ADDR_W-1:0] idx;
    assign access = MemWriteM | ResultSrcM;
    assign idx = ALU_ResultM[ADDR_W+1:2];
    assign unused_addr = ^{ALU_ResultM[31:ADDR_W+2], ALU_ResultM[1:0]};
    assign StallM = rst & access & (cnt != LAST);
    assign ResultW = ResultSrcW ? ReadDataW : ALU_ResultW;
    always_comb begin
        state_n = IDLE;
        cnt_n = '0;
        if (StallM) begin
            state_n = BUSY;
            cnt_n = (state == IDLE) ? CW'(1) : cnt + CW'(1);
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
        end
    end
    // memory is deliberately not reset; the store lands only on the completing edge
    always_ff @(posedge clk) begin
        if (rst && access && !StallM && MemWriteM) mem[idx] <= WriteDataM;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteW <= 1'b0;
            RD_W <= '0;
            ResultSrcW <= 1'b0;
            ALU_ResultW <= '0;
            ReadDataW <= '0;
            PCPlus4W <= '0;
        end else if (StallM) begin
            RegWriteW <= 1'b0;
            ResultSrcW <= 1'b0;
        end else begin
            RegWriteW <= RegWriteM;
            RD_W <= RD_M;
            ResultSrcW <= ResultSrcM;
            ALU_ResultW <= ALU_ResultM;
            ReadDataW <= mem[idx];
            PCPlus4W <= PCPlus4M;
        end
    end
endmodule

// File: tb/tb_memory_cycle.sv
// tb_memory_cycle: directed checks on a 1-cycle and a 3-cycle memory_cycle instance
module tb_memory_cycle;
    typedef struct packed {
        logic        rw;
        logic        mw;
        logic        rs;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] wd;
        logic [31:0] alu;
    } m_t;
    logic clk, rst;
    m_t i1, i3;
    logic s1, rw1, rsw1, s3, rw3, rsw3;
    logic [4:0] rd1, rd3;
    logic [31:0] alu1, rdat1, pc1, res1, alu3, rdat3, pc3, res3;
    int checks = 0, passes = 0;

    memory_cycle #(.DEPTH(1024), .ADDR_W(10), .MEM_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .RegWriteM(i1.rw), .MemWriteM(i1.mw), .ResultSrcM(i1.rs),
        .RD_M(i1.rd), .PCPlus4M(i1.pc), .WriteDataM(i1.wd), .ALU_ResultM(i1.alu),
        .StallM(s1), .RegWriteW(rw1), .RD_W(rd1), .ResultSrcW(rsw1), .ALU_ResultW(alu1),
        .ReadDataW(rdat1), .PCPlus4W(pc1), .ResultW(res1));
    memory_cycle #(.DEPTH(1024), .ADDR_W(10), .MEM_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .RegWriteM(i3.rw), .MemWriteM(i3.mw), .ResultSrcM(i3.rs),
        .RD_M(i3.rd), .PCPlus4M(i3.pc), .WriteDataM(i3.wd), .ALU_ResultM(i3.alu),
        .StallM(s3), .RegWriteW(rw3), .RD_W(rd3), .ResultSrcW(rsw3), .ALU_ResultW(alu3),
        .ReadDataW(rdat3), .PCPlus4W(pc3), .ResultW(res3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else passes++;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        i1 = '0;
        i3 = '{rw:1'b1, mw:1'b1, rs:1'b0, rd:5'd1, pc:32'h4, wd:32'h1, alu:32'h0};
        tick(2);
        chk("reset_rw1", {31'b0, rw1}, 32'h0);
        chk("reset_res1", res1, 32'h0);
        chk("reset_pc3", pc3, 32'h0);
        chk("reset_stall3", {31'b0, s3}, 32'h0);
        i3 = '0;
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_alu_pass;
        i1 = '{rw:1'b1, mw:1'b0, rs:1'b0, rd:5'd5, pc:32'h8, wd:32'h0, alu:32'h30};
        #1;
        chk("alu_stall_before", {31'b0, s1}, 32'h0);
        tick(1);
        chk("alu_rw", {31'b0, rw1}, 32'h1);
        chk("alu_rd", {27'b0, rd1}, 32'd5);
        chk("alu_result", res1, 32'h30);
        chk("alu_pc", pc1, 32'h8);
        chk("alu_stall_after", {31'b0, s1}, 32'h0);
    endtask

    task automatic test_store_load;
        i1 = '{rw:1'b0, mw:1'b1, rs:1'b0, rd:5'd0, pc:32'hC, wd:32'hDEADBEEF, alu:32'h10};
        #1;
        chk("st_stall", {31'b0, s1}, 32'h0);
        tick(1);
        chk("st_rw", {31'b0, rw1}, 32'h0);
        i1 = '{rw:1'b1, mw:1'b0, rs:1'b1, rd:5'd7, pc:32'h10, wd:32'h0, alu:32'h13};
        tick(1);
        chk("ld_readdata", rdat1, 32'hDEADBEEF);
        chk("ld_result", res1, 32'hDEADBEEF);
        chk("ld_rd", {27'b0, rd1}, 32'd7);
        chk("ld_rsw", {31'b0, rsw1}, 32'h1);
    endtask

    task automatic test_wrap;
        i1 = '{rw:1'b0, mw:1'b1, rs:1'b0, rd:5'd0, pc:32'h14, wd:32'h77, alu:32'h1004};
        tick(1);
        i1 = '{rw:1'b1, mw:1'b0, rs:1'b1, rd:5'd3, pc:32'h18, wd:32'h0, alu:32'h4};
        tick(1);
        chk("wrap_result", res1, 32'h77);
        i1 = '0;
    endtask

    task automatic test_rw_same;
        i1 = '{rw:1'b1, mw:1'b1, rs:1'b1, rd:5'd2, pc:32'h1C, wd:32'h99, alu:32'h4};
        tick(1);
        chk("rmw_old", res1, 32'h77);
        i1 = '{rw:1'b1, mw:1'b0, rs:1'b1, rd:5'd2, pc:32'h20, wd:32'h0, alu:32'h4};
        tick(1);
        chk("rmw_new", res1, 32'h99);
        i1 = '0;
    endtask

    task automatic test_mc_store;
        i3 = '{rw:1'b0, mw:1'b1, rs:1'b0, rd:5'd0, pc:32'h4, wd:32'h11, alu:32'h20};
        tick(3);
        i3.wd = 32'hA5A5A5A5;
        #1;
        chk("mst_stall0", {31'b0, s3}, 32'h1);
        tick(1);
        chk("mst_mem_e1", dut3.mem[8], 32'h11);
        chk("mst_stall1", {31'b0, s3}, 32'h1);
        tick(1);
        chk("mst_mem_e2", dut3.mem[8], 32'h11);
        chk("mst_stall2", {31'b0, s3}, 32'h0);
        tick(1);
        chk("mst_mem_e3", dut3.mem[8], 32'hA5A5A5A5);
        i3 = '{rw:1'b1, mw:1'b0, rs:1'b1, rd:5'd4, pc:32'h8, wd:32'h0, alu:32'h20};
        tick(3);
        chk("mst_load", res3, 32'hA5A5A5A5);
    endtask

    task automatic test_mc_load;
        i3 = '{rw:1'b0, mw:1'b1, rs:1'b0, rd:5'd0, pc:32'hC, wd:32'h1234, alu:32'h10};
        tick(3);
        i3 = '{rw:1'b1, mw:1'b0, rs:1'b1, rd:5'd9, pc:32'h10, wd:32'h0, alu:32'h10};
        #1;
        chk("mld_stall0", {31'b0, s3}, 32'h1);
        tick(1);
        chk("mld_rw_e1", {31'b0, rw3}, 32'h0);
        chk("mld_stall1", {31'b0, s3}, 32'h1);
        tick(1);
        chk("mld_rw_e2", {31'b0, rw3}, 32'h0);
        chk("mld_stall2", {31'b0, s3}, 32'h0);
        tick(1);
        chk("mld_rw_e3", {31'b0, rw3}, 32'h1);
        chk("mld_result", res3, 32'h1234);
        chk("mld_rd", {27'b0, rd3}, 32'd9);
        chk("mld_cnt", 32'(dut3.cnt), 32'h0);
        i3 = '0;
        tick(1);
        chk("nonaccess_stall", {31'b0, s3}, 32'h0);
    endtask

    task automatic test_reset_mid;
        i3 = '{rw:1'b0, mw:1'b1, rs:1'b0, rd:5'd0, pc:32'h14, wd:32'h0, alu:32'h8};
        tick(3);
        i3 = '{rw:1'b1, mw:1'b0, rs:1'b0, rd:5'd6, pc:32'h18, wd:32'h0, alu:32'h55};
        tick(1);
        i3 = '{rw:1'b0, mw:1'b1, rs:1'b0, rd:5'd0, pc:32'h1C, wd:32'hDEAD, alu:32'h8};
        tick(1);
        chk("rst_mid_stall_pre", {31'b0, s3}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_alu", alu3, 32'h0);
        chk("rst_mid_pc", pc3, 32'h0);
        chk("rst_mid_rd", {27'b0, rd3}, 32'h0);
        chk("rst_mid_stall", {31'b0, s3}, 32'h0);
        i3 = '0;
        @(negedge clk);
        rst = 1'b1;
        tick(2);
        chk("rst_mid_mem", dut3.mem[2], 32'h0);
        i3 = '{rw:1'b1, mw:1'b0, rs:1'b1, rd:5'd1, pc:32'h20, wd:32'h0, alu:32'h8};
        tick(3);
        chk("rst_mid_load", res3, 32'h0);
    endtask

    initial begin
        test_reset();
        test_alu_pass();
        test_store_load();
        test_wrap();
        test_rw_same();
        test_mc_store();
        test_mc_load();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/memory_cycle.md
Name: memory_cycle

Overview:
- Pipeline stage downstream of the execute stage; consumes the execute stage's M-side outputs.
- Performs data-memory loads and stores with a configurable access latency, stalling upstream while busy.
- Registers results into the M/W pipeline register.
- Returns ResultW to the execute stage's forwarding muxes, and RegWriteW/RD_W to the hazard unit.

Parameters:
DEPTH, 1024, data memory size in 32-bit words
ADDR_W, 10, word-address width; must equal log2(DEPTH)
MEM_LATENCY, 1, cycles a load/store occupies the M stage (>=1); 1 means no stall

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
RegWriteM  input  1  register write enable from execute stage
MemWriteM  input  1  store enable
ResultSrcM  input  1  1 = load (result from memory), 0 = ALU result
RD_M  input  5  destination register
PCPlus4M  input  32  PC+4 of instruction in M
WriteDataM  input  32  store data (already forwarded)
ALU_ResultM  input  32  ALU result / effective byte address
StallM  output  1  M stage busy; upstream holds E/M register and all earlier stages
RegWriteW  output  1  registered write enable
RD_W  output  5  registered destination register
ResultSrcW  output  1  registered result select
ALU_ResultW  output  32  registered ALU result
ReadDataW  output  32  registered load data
PCPlus4W  output  32  registered PC+4
ResultW  output  32  combinational: ResultSrcW ? ReadDataW : ALU_ResultW

Behaviour:
- Access definition: access = MemWriteM | ResultSrcM. Word index = ALU_ResultM[ADDR_W+1:2]; bits [1:0] ignored. Upper bits are truncated, so addresses wrap modulo DEPTH.
- Memory is not reset. Reads are asynchronous from the array. Writes occur on the clk edge only.
- Latency counter cnt, range 0..MEM_LATENCY-1, reset 0. FSM states:
  - IDLE (cnt=0).
  - BUSY (0<cnt).
- StallM = rst & access & (cnt != MEM_LATENCY-1). With MEM_LATENCY=1, StallM is always 0.
- State transitions on each edge with access=1:
  - If StallM=1: cnt <= cnt+1, state BUSY.
  - Else, the completing cycle: cnt <= 0, state IDLE; if MemWriteM, mem[index] <= WriteDataM.
- Exactly one write per store, on the completing edge only.
- Upstream must keep M inputs stable while StallM=1. Any input change during BUSY is a protocol violation; behaviour is unspecified.
- M/W register, on a completing or non-access edge: RegWriteW, RD_W, ResultSrcW, ALU_ResultW, PCPlus4W load from the M inputs; ReadDataW <= mem[index] (pre-write contents).
- While StallM=1, the M/W register inserts a bubble: RegWriteW <= 0, ResultSrcW <= 0; other W fields hold.
- Non-access instructions: 1-cycle pass-through, no stall.
- Simultaneous MemWriteM and ResultSrcM: treated as one access; the store is performed; ReadDataW gets the old word (read-before-write).
- A load immediately following a store to the same word returns the newly stored data.
- RD_M=0 with RegWriteM=1 propagates unchanged; suppressing x0 writes is the register file's job.
- Reset (rst=0), asynchronous:
  - All W outputs 0, so ResultW = 0.
  - cnt=0, state IDLE; StallM forced 0 while rst=0.
  - Reset mid-access aborts it: no memory write occurs unless the completing edge preceded reset.
- After reset release, the first edge processes current inputs normally.

Test Plan:
- ALU pass-through (MEM_LATENCY=1): RegWriteM=1, ResultSrcM=0, RD_M=5, ALU_ResultM=32'h30, PCPlus4M=32'h8.
  - Required after 1 edge: RegWriteW=1, RD_W=5, ResultW=32'h30, PCPlus4W=32'h8, StallM=0 throughout.
- Store then load (MEM_LATENCY=1): store WriteDataM=32'hDEADBEEF, ALU_ResultM=32'h10, then load ALU_ResultM=32'h13, RD_M=7.
  - Required one edge after the load: ReadDataW=32'hDEADBEEF, ResultW=32'hDEADBEEF, RD_W=7. During the store cycle RegWriteW follows RegWriteM=0.
- Multi-cycle load (MEM_LATENCY=3): load from word 4 holding 32'h1234.
  - Required: StallM=1 for 2 cycles, RegWriteW=0 after each stall edge.
  - On the 3rd edge: StallM=0, RegWriteW=1, ResultW=32'h1234; cnt back to 0.
- Multi-cycle store (MEM_LATENCY=3) to ALU_ResultM=32'h20, data 32'hA5A5A5A5.
  - Required: memory word 8 unchanged after edges 1–2, updated after edge 3; a subsequent load returns 32'hA5A5A5A5.
- Address wrap (DEPTH=1024): store 32'h77 at ALU_ResultM=32'h1004, then load ALU_ResultM=32'h4.
  - Required: returns 32'h77.
- Reset mid-access (MEM_LATENCY=3): store pending at word 2 (old value 32'h0), drive rst=0 after the 1st stall edge, asynchronously between edges.
  - Required: W outputs 0 immediately, StallM=0.
  - After release with MemWriteM=0, word 2 still reads 32'h0.
